// File: rtl/clock_display_serializer_if.sv
// Digit inputs, refresh/busy handshake and 3-wire serial link of the
// clock display serializer. The slave modport is the serializer side.
interface clock_display_serializer_if;
  logic       refresh;
  logic [3:0] hours_msd;
  logic [3:0] hours_lsd;
  logic [3:0] minutes_msd;
  logic [3:0] minutes_lsd;
  logic [3:0] seconds_msd;
  logic [3:0] seconds_lsd;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       busy;

  modport master (
    output refresh, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
           seconds_msd, seconds_lsd,
    input  cs_n, sclk, mosi, busy
  );

  modport slave (
    input  refresh, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
           seconds_msd, seconds_lsd,
    output cs_n, sclk, mosi, busy
  );
endinterface

// File: rtl/clock_display_serializer.sv
// Clock display serializer: snapshots HH:MM:SS BCD digits and shifts them
// to a MAX7219-style driver as 16-bit words over cs_n/sclk/mosi. Sends a
// four-word driver configuration after reset, then one six-word digit
// frame per refresh request (one request can be queued while busy).
// Optional: DISPLAY_DP_BLINK_EN drives the dp bit of digits 2 and 4 from
// the inverted seconds LSB to make blinking colon separators.
module clock_display_serializer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [7:0]  INTENSITY = 8'h08
) (
  input logic                        clk,
  input logic                        reset,
  clock_display_serializer_if.slave  bus
);

  typedef enum logic [2:0] {INIT, IDLE, LOAD, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // cycles within current sclk phase / gap
  logic [3:0]  bit_q, bit_d;       // bit currently on mosi
  logic [2:0]  widx_q, widx_d;     // word index within init sequence / frame
  logic        init_q, init_d;     // 1: sending configuration words
  logic        pending_q, pending_d;
  logic [15:0] shift_q, shift_d;   // word being shifted, MSB on mosi
  logic [23:0] snap_q, snap_d;     // digit snapshot for the current frame
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;

  logic [23:0] live;
  logic [23:0] src;
  logic [3:0]  nib;
  logic        dp;
  logic [15:0] word;
  logic        last_word;

  assign live = {bus.hours_msd, bus.hours_lsd, bus.minutes_msd,
                 bus.minutes_lsd, bus.seconds_msd, bus.seconds_lsd};

  // Build the word for the current index; the first frame word reads the
  // live digits because the snapshot is only being captured in that cycle.
  always_comb begin
    src = (widx_q == 3'd0) ? live : snap_q;
    nib = 4'h0;
    dp  = 1'b0;
    case (widx_q)
      3'd0:    nib = src[23:20];
      3'd1:    nib = src[19:16];
      3'd2:    nib = src[15:12];
      3'd3:    nib = src[11:8];
      3'd4:    nib = src[7:4];
      default: nib = src[3:0];
    endcase
    if (nib > 4'd9) nib = 4'hF;
`ifdef DISPLAY_DP_BLINK_EN
    dp = ((widx_q == 3'd1) || (widx_q == 3'd3)) && !src[0];
`endif
    word = {4'h0, {1'b0, widx_q} + 4'd1, dp, 3'b000, nib};
    if (init_q) begin
      case (widx_q)
        3'd0:    word = 16'h0C01;
        3'd1:    word = 16'h093F;
        3'd2:    word = 16'h0B05;
        default: word = {8'h0A, INTENSITY};
      endcase
    end
    last_word = init_q ? (widx_q == 3'd3) : (widx_q == 3'd5);
  end

  // Sequencer: load, shift 16 bits with CLK_DIV-cycle sclk phases, gap,
  // then next word, idle, or a queued frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    widx_d    = widx_q;
    init_d    = init_q;
    shift_d   = shift_q;
    snap_d    = snap_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    pending_d = pending_q | (bus.refresh & (state_q != IDLE));
    case (state_q)
      INIT, LOAD: begin
        if ((state_q == LOAD) && (widx_q == 3'd0)) snap_d = live;
        shift_d = word;
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = word[15];
        cnt_d   = 8'd0;
        bit_d   = 4'd15;
        state_d = SHIFT;
      end
      IDLE: begin
        if (bus.refresh) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          widx_d  = 3'd0;
          init_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = GAP;
          end else begin
            sclk_d  = 1'b0;
            bit_d   = bit_q - 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
            mosi_d  = shift_q[14];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 8'd0;
          if (last_word) begin
            init_d = 1'b0;
            widx_d = 3'd0;
            if (pending_q || bus.refresh) begin
              // A refresh arriving now while a request is already queued
              // stays queued behind the frame being started.
              state_d   = LOAD;
              pending_d = pending_q & bus.refresh;
            end else begin
              state_d   = IDLE;
              busy_d    = 1'b0;
              pending_d = 1'b0;
            end
          end else begin
            widx_d  = widx_q + 3'd1;
            state_d = init_q ? INIT : LOAD;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any word and re-arms init.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      cnt_q     <= 8'd0;
      bit_q     <= 4'd0;
      widx_q    <= 3'd0;
      init_q    <= 1'b1;
      pending_q <= 1'b0;
      shift_q   <= 16'h0000;
      snap_q    <= 24'h000000;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      widx_q    <= widx_d;
      init_q    <= init_d;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      snap_q    <= snap_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cs_n = cs_n_q;
  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;

endmodule
